// File: rtl/rst_seq_ctrl.sv
// Power-up reset sequencer: holds every domain in reset, releases them in order, then waits for ready.
// Optional macro RST_SEQ_CTRL_RETRY_EN adds automatic retries after a ready timeout.
module rst_seq_ctrl #(
  parameter int NUM_STAGES  = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8,
  parameter int RDY_TIMEOUT = 1024,
  parameter int MAX_RETRY   = 3
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  pwr2rst_rst_ctrl_start,
  input  logic                  sw_rst_req,
  input  logic                  rdy_in,
  output logic [NUM_STAGES-1:0] stage_rst_,
  output logic                  rst_ctrl_busy,
  output logic                  rst_ctrl_done,
  output logic                  rst_ctrl_err
);

  localparam int MAX_HG  = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int MAX_CNT = (MAX_HG > RDY_TIMEOUT) ? MAX_HG : RDY_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_CNT) + 1;
  localparam int IDX_W   = $clog2(NUM_STAGES) + 1;

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(STAGE_GAP);
  localparam logic [CNT_W-1:0] RDY_LD  = CNT_W'(RDY_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST_IX = IDX_W'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] STAGE_ONE = NUM_STAGES'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_RELEASE,
    ST_WAIT_RDY,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_STAGES-1:0]   stage_q, stage_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    restart;
  logic                    cnt_expired;

`ifdef RST_SEQ_CTRL_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  logic [RETRY_W-1:0] retry_q, retry_d;
`else
  logic unused_max_retry;
  assign unused_max_retry = (MAX_RETRY != 0);
`endif

  // A start pulse only counts when no sequence is running; sw_rst_req always restarts.
  assign restart = sw_rst_req ||
                   (pwr2rst_rst_ctrl_start &&
                    (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR));
  assign cnt_expired = (cnt_q <= CNT_ONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
`ifdef RST_SEQ_CTRL_RETRY_EN
    retry_d = retry_q;
`endif

    case (state_q)
      ST_ASSERT: begin
        if (cnt_expired) begin
          state_d = ST_RELEASE;
          stage_d = STAGE_ONE;
          idx_d   = '0;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_RELEASE: begin
        if (!cnt_expired) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (idx_q == LAST_IX) begin
          state_d = ST_WAIT_RDY;
          cnt_d   = RDY_LD;
        end else begin
          stage_d = stage_q | (STAGE_ONE << (idx_q + IDX_ONE));
          idx_d   = idx_q + IDX_ONE;
          cnt_d   = GAP_LD;
        end
      end
      ST_WAIT_RDY: begin
        if (rdy_in) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
`ifdef RST_SEQ_CTRL_RETRY_EN
          retry_d = '0;
`endif
        end else if (cnt_expired) begin
`ifdef RST_SEQ_CTRL_RETRY_EN
          if (retry_q < RETRY_MAX) begin
            state_d = ST_ASSERT;
            cnt_d   = HOLD_LD;
            idx_d   = '0;
            stage_d = '0;
            retry_d = retry_q + RETRY_W'(1);
          end else begin
            state_d = ST_ERR;
            busy_d  = 1'b0;
            err_d   = 1'b1;
            stage_d = '0;
            cnt_d   = '0;
          end
`else
          state_d = ST_ERR;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          stage_d = '0;
          cnt_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: ;
    endcase

    // Any accepted request overrides whatever the state machine decided above.
    if (restart) begin
      state_d = ST_ASSERT;
      cnt_d   = HOLD_LD;
      idx_d   = '0;
      stage_d = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end
`ifdef RST_SEQ_CTRL_RETRY_EN
    if (pwr2rst_rst_ctrl_start || sw_rst_req) begin
      retry_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef RST_SEQ_CTRL_RETRY_EN
      retry_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef RST_SEQ_CTRL_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

  assign stage_rst_    = stage_q;
  assign rst_ctrl_busy = busy_q;
  assign rst_ctrl_done = done_q;
  assign rst_ctrl_err  = err_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: expected output snapshots are queued per clock edge and
// compared when that edge's outputs are visible; also covers RST_SEQ_CTRL_RETRY_EN when defined.
module tb_rst_seq_ctrl;

  localparam int NS = 4;

  typedef struct packed {
    logic [31:0]   cyc;
    logic [NS-1:0] stage;
    logic          busy;
    logic          done;
    logic          err;
  } exp_t;

  logic          clk;
  logic          rst_;
  logic          start_pulse;
  logic          sw_rst_req;
  logic          rdy_in;
  logic [NS-1:0] stage_rst_;
  logic          busy;
  logic          done;
  logic          err;

  int unsigned   cyc = 0;
  int unsigned   check_cnt = 0;
  int unsigned   pass_cnt = 0;
  int unsigned   fail_cnt = 0;
  exp_t          exp_q[$];
  string         tag_q[$];
  logic [NS-1:0] mon_plus;

  rst_seq_ctrl dut (
    .clk                    (clk),
    .rst_                   (rst_),
    .pwr2rst_rst_ctrl_start (start_pulse),
    .sw_rst_req             (sw_rst_req),
    .rdy_in                 (rdy_in),
    .stage_rst_             (stage_rst_),
    .rst_ctrl_busy          (busy),
    .rst_ctrl_done          (done),
    .rst_ctrl_err           (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic pushExp(input logic [31:0] c, input logic [NS-1:0] st, input logic b,
                         input logic d, input logic e, input string tag);
    exp_t x;
    x.cyc = c; x.stage = st; x.busy = b; x.done = d; x.err = e;
    exp_q.push_back(x);
    tag_q.push_back(tag);
  endtask

  task automatic checkOutput();
    exp_t          ex;
    string         tg;
    logic [NS+2:0] act;
    logic [NS+2:0] want;
    ex   = exp_q.pop_front();
    tg   = tag_q.pop_front();
    act  = {stage_rst_, busy, done, err};
    want = {ex.stage, ex.busy, ex.done, ex.err};
    check_cnt++;
    assert (act === want) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s at edge %0d: observed stage=%b busy=%b done=%b err=%b, expected stage=%b busy=%b done=%b err=%b",
             tg, cyc, stage_rst_, busy, done, err, ex.stage, ex.busy, ex.done, ex.err);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic sw);
    start_pulse = st;
    sw_rst_req  = sw;
    @(negedge clk);
    start_pulse = 1'b0;
    sw_rst_req  = 1'b0;
  endtask

  task automatic waitUntil(input int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  // Scoreboard pop plus per-cycle invariants, sampled mid-period.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc == cyc) checkOutput();
    mon_plus = stage_rst_ + 1'b1;
    check_cnt++;
    assert ((stage_rst_ & mon_plus) == '0 && (32'(busy) + 32'(done) + 32'(err)) <= 1) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL invariant at edge %0d: observed stage=%b busy=%b done=%b err=%b, expected monotonic stages and at most one status",
             cyc, stage_rst_, busy, done, err);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed edge %0d, expected completion", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int unsigned e0, s, t0, r, s2, c;
    rst_        = 1'b0;
    start_pulse = 1'b0;
    sw_rst_req  = 1'b0;
    rdy_in      = 1'b0;
    #1;
    pushExp(cyc, '0, 0, 0, 0, "reset_values");
    checkOutput();
    #20 rst_ = 1'b1;
    @(negedge clk);
    pushExp(cyc + 2, '0, 0, 0, 0, "idle_no_start");
    waitUntil(cyc + 3);

    // Power-up sequence with default parameters.
    e0 = cyc + 1;
    pushExp(e0,      4'b0000, 1, 0, 0, "t1_busy_at_start");
    pushExp(e0 + 15, 4'b0000, 1, 0, 0, "t1_hold_end");
    pushExp(e0 + 16, 4'b0001, 1, 0, 0, "t1_stage0");
    pushExp(e0 + 23, 4'b0001, 1, 0, 0, "t1_gap0");
    pushExp(e0 + 24, 4'b0011, 1, 0, 0, "t1_stage1");
    pushExp(e0 + 32, 4'b0111, 1, 0, 0, "t1_stage2");
    pushExp(e0 + 40, 4'b1111, 1, 0, 0, "t1_stage3");
    pushExp(e0 + 49, 4'b1111, 1, 0, 0, "t1_wait_rdy");
    pushExp(e0 + 50, 4'b1111, 0, 1, 0, "t1_done");
    pushExp(e0 + 56, 4'b1111, 0, 1, 0, "t1_done_ignores_rdy_drop");
    applyStimulus(1'b1, 1'b0);
    waitUntil(e0 + 49);
    rdy_in = 1'b1;
    waitUntil(e0 + 52);
    rdy_in = 1'b0;
    waitUntil(e0 + 56);

    // Software reset from DONE, ready already high.
    rdy_in = 1'b1;
    s = cyc + 1;
    pushExp(s,      4'b0000, 1, 0, 0, "t2_sw_from_done");
    pushExp(s + 16, 4'b0001, 1, 0, 0, "t2_stage0");
    pushExp(s + 40, 4'b1111, 1, 0, 0, "t2_stage3");
    pushExp(s + 48, 4'b1111, 1, 0, 0, "t2_wait_entry");
    pushExp(s + 49, 4'b1111, 0, 1, 0, "t2_done_again");
    applyStimulus(1'b0, 1'b1);
    waitUntil(s + 49);
    rdy_in = 1'b0;
    waitUntil(s + 52);

    // Start from DONE, software reset mid-sequence, ignored start while busy.
    t0 = cyc + 1;
    pushExp(t0,      4'b0000, 1, 0, 0, "t3_start_from_done");
    pushExp(t0 + 29, 4'b0011, 1, 0, 0, "t3_before_sw");
    applyStimulus(1'b1, 1'b0);
    waitUntil(t0 + 29);
    r = cyc + 1;
    pushExp(r,      4'b0000, 1, 0, 0, "t3_sw_midseq");
    pushExp(r + 5,  4'b0000, 1, 0, 0, "t3_start_ignored");
    pushExp(r + 15, 4'b0000, 1, 0, 0, "t3_hold_end");
    pushExp(r + 16, 4'b0001, 1, 0, 0, "t3_rerelease");
    pushExp(r + 24, 4'b0011, 1, 0, 0, "t3_stage1");
`ifndef RST_SEQ_CTRL_RETRY_EN
    pushExp(r + 1071, 4'b1111, 1, 0, 0, "t3_wait_last");
    pushExp(r + 1072, 4'b0000, 0, 0, 1, "t3_timeout_err");
    pushExp(r + 1080, 4'b0000, 0, 0, 1, "t3_err_hold");
    applyStimulus(1'b0, 1'b1);
    waitUntil(r + 4);
    applyStimulus(1'b1, 1'b0);
    waitUntil(r + 1080);
    s2 = cyc + 1;
    pushExp(s2,      4'b0000, 1, 0, 0, "t4_err_clears");
    pushExp(s2 + 16, 4'b0001, 1, 0, 0, "t4_stage0");
    pushExp(s2 + 20, 4'b0001, 1, 0, 0, "t5_pre_reset");
    applyStimulus(1'b0, 1'b1);
`else
    for (int k = 1; k < 4; k++) begin
      pushExp(r + 1072 * k,      4'b0000, 1, 0, 0, "tr_retry_restart");
      pushExp(r + 1072 * k + 15, 4'b0000, 1, 0, 0, "tr_hold_end");
      pushExp(r + 1072 * k + 16, 4'b0001, 1, 0, 0, "tr_stage0_again");
    end
    pushExp(r + 4287, 4'b1111, 1, 0, 0, "tr_last_wait");
    pushExp(r + 4288, 4'b0000, 0, 0, 1, "tr_err_after_retries");
    applyStimulus(1'b0, 1'b1);
    waitUntil(r + 4);
    applyStimulus(1'b1, 1'b0);
    waitUntil(r + 4290);
    s2 = cyc + 1;
    pushExp(s2,             4'b0000, 1, 0, 0, "tr2_sw_from_err");
    pushExp(s2 + 1072,      4'b0000, 1, 0, 0, "tr2_first_retry");
    pushExp(s2 + 1072 + 48, 4'b1111, 1, 0, 0, "tr2_wait");
    pushExp(s2 + 1072 + 49, 4'b1111, 0, 1, 0, "tr2_done");
    pushExp(s2 + 1072 + 60, 4'b1111, 0, 1, 0, "tr2_done_hold");
    applyStimulus(1'b0, 1'b1);
    waitUntil(s2 + 1082);
    rdy_in = 1'b1;
    waitUntil(s2 + 1072 + 60);
    rdy_in = 1'b0;
    s2 = cyc + 1;
    pushExp(s2,      4'b0000, 1, 0, 0, "t4_sw_from_done");
    pushExp(s2 + 16, 4'b0001, 1, 0, 0, "t4_stage0");
    pushExp(s2 + 20, 4'b0001, 1, 0, 0, "t5_pre_reset");
    applyStimulus(1'b0, 1'b1);
`endif

    // Asynchronous reset mid-sequence, away from any clock edge.
    waitUntil(s2 + 20);
    #2 rst_ = 1'b0;
    #1;
    pushExp(cyc, '0, 0, 0, 0, "t5_async_reset");
    checkOutput();
    @(negedge clk);
    @(negedge clk);
    #2 rst_ = 1'b1;
    @(negedge clk);
    c = cyc;
    pushExp(c + 5, '0, 0, 0, 0, "t5_idle_after_reset");
    waitUntil(c + 6);

    check_cnt++;
    assert (exp_q.size() == 0) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL scoreboard_drain: observed %0d pending entries, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
